icache_param: RTL and testbench
===============================

# icache_param

Parametrised direct-mapped instruction cache between the fetch stage and the memory controller, successor to the fixed 16-frame icache. Sets and words-per-block are configurable. Misses are filled by a block-refill FSM; data-side memory traffic takes priority over the fill. A flush input invalidates all lines.

## Interface

Parameters:

- SETS, 16: number of lines; power of 2, ≥2.
- WORDS, 2: 32-bit words per block; power of 2, ≥1.

Derived fields (32-bit byte address):

- IDX_W = log2(SETS)
- OFF_W = log2(WORDS)
- TAG_W = 30 − IDX_W − OFF_W
- Address split: tag [31:32−TAG_W], index, word offset, byte [1:0].

Ports:

- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- dREN  in  1  data-side read active; blocks the fill.
- dWEN  in  1  data-side write active; blocks the fill.
- iflush  in  1  invalidate all lines; one-cycle pulse or level.
- ihit  out  1  imemload is valid this cycle.
- imemload  out  32  instruction word.
- mem_iREN  out  1  refill read request to the memory controller.
- mem_iaddr  out  32  refill word address.
- mem_iwait  in  1  memory not ready; the word on mem_iload is not valid.
- mem_iload  in  32  refill data.

## Operation

Storage per set:

- valid bit
- TAG_W tag
- WORDS×32 data

Only valid and the FSM state are reset. Tags and data are not reset.

Latched miss registers:

- miss_tag, miss_idx
- word counter cnt, OFF_W bits; width 1 when WORDS=1

FSM states: IDLE, FILL.

IDLE:

- hit = iREN & valid[idx] & (tag[idx]==addr tag) & !iflush.
- ihit = hit. imemload = data[idx][offset] (combinational).
- Miss condition: iREN & !hit & !iflush.
- On a miss, latch tag/idx, set cnt=0, go to FILL.

FILL:

- mem_iREN = !(dREN|dWEN).
- mem_iaddr = {miss_tag, miss_idx, cnt, 2'b00}.
- ihit = 0.
- If mem_iREN & !mem_iwait:
  - write mem_iload into data[miss_idx][cnt];
  - if cnt==WORDS−1: write tag, set valid, go to IDLE;
  - otherwise cnt++.
- If dREN|dWEN: mem_iREN=0; cnt and state hold; any mem_iload is ignored.
- iREN dropping or imemaddr changing during FILL: the fill still completes.
- iflush during FILL: abort and go to IDLE. Partially written data is discarded, and valid stays 0 for all sets.

iflush in any state: all valid bits cleared at the next edge. ihit=0 while iflush is high.

Replacement: a fill overwrites the indexed set unconditionally (direct-mapped).

Outputs at reset:

- ihit=0, mem_iREN=0, mem_iaddr=0.
- imemload undefined; it is don't-care while ihit=0.
- state=IDLE, all valid=0.

## Timing

- Hit latency: 0 cycles; ihit is combinational in the request cycle.
- Miss latency with mem_iwait=0 and no data traffic:
  - miss seen in cycle 0;
  - FILL occupies cycles 1..WORDS;
  - ihit in cycle WORDS+1 if the request is held.
- Each mem_iwait=1 cycle or dREN|dWEN cycle adds one cycle.
- mem_iREN and mem_iaddr are stable while mem_iwait=1.
- mem_iaddr changes only after an accepted word.
- nRST asserted asynchronously mid-fill:
  - immediate IDLE, all valid=0, mem_iREN=0;
  - no partial line becomes valid.
- Simultaneous events:
  - iflush and last-word accept in the same cycle: flush wins; the line is not valid.
  - dREN and last word in the same cycle: the word is not accepted.

## Test plan

Defaults (SETS=16, WORDS=2): tag [31:7], idx [6:3], off [2].

- Reset, then iREN=1, imemaddr=0x104:
  - mem_iREN=1, mem_iaddr=0x100 and then 0x104;
  - feed 0xAAAA0000 and 0xBBBB0001 with iwait=0;
  - cycle 3: ihit=1, imemload=0xBBBB0001;
  - next, address 0x100 hits in the same cycle with 0xAAAA0000.
- Conflict: after the line above is filled, request 0x904 (idx 0, tag 0x12):
  - miss, fill from 0x900/0x904;
  - re-request 0x100 → miss (line replaced).
- Wait states: mem_iwait=1 for 3 cycles on each word:
  - mem_iaddr holds 0x100 for 4 cycles;
  - ihit arrives at cycle 9;
  - imemload is correct.
- Data priority: dREN=1 for 2 cycles after the first word is accepted:
  - mem_iREN=0 during those cycles, mem_iaddr stays 0x104;
  - the fill resumes and completes; ihit is delayed by 2 cycles.
- iflush during word 1 of a fill:
  - state → IDLE, mem_iREN=0;
  - re-request 0x104 → full miss;
  - a previously filled 0x900 also misses.
- nRST low mid-FILL:
  - ihit=0 and mem_iREN=0 immediately;
  - after release, 0x100 misses.

Source files
------------

// File: rtl/icache_param.sv
// icache_param: parametrised direct-mapped instruction cache.
// A miss latches the missing line and a two-state FSM refills it one word
// per accepted memory beat. Data-side traffic stalls the refill, and a
// flush aborts any refill and invalidates every line.
module icache_param #(
  parameter int SETS  = 16,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] imemaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        mem_iREN,
  output logic [31:0] mem_iaddr,
  input  logic        mem_iwait,
  input  logic [31:0] mem_iload
);
  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = $clog2(WORDS);
  localparam int CNT_W = (OFF_W == 0) ? 1 : OFF_W;
  localparam int TAG_W = 30 - IDX_W - OFF_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            r_state, w_state_nxt;
  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [31:0]       r_data [SETS][WORDS];
  logic [TAG_W-1:0]  r_miss_tag;
  logic [IDX_W-1:0]  r_miss_idx;
  logic [CNT_W-1:0]  r_cnt;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [CNT_W-1:0]  w_off;
  logic              w_hit, w_miss, w_dbusy, w_last, w_accept;
  logic [31:0]       w_fill_addr;
  logic              w_unused_bits;

  assign w_tag = imemaddr[31 -: TAG_W];
  assign w_idx = imemaddr[2+OFF_W +: IDX_W];

  // Single-word blocks have no offset field; the counter is then a dummy bit.
  generate
    if (WORDS == 1) begin : g_off_w1
      assign w_off = '0;
    end else begin : g_off_wn
      assign w_off = imemaddr[2 +: OFF_W];
    end
  endgenerate

  assign w_unused_bits = ^imemaddr[1:0];

  assign w_hit   = iREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag) & ~iflush;
  assign w_miss  = (r_state == IDLE) & iREN & ~w_hit & ~iflush;
  assign w_dbusy = dREN | dWEN;
  assign w_last  = (r_cnt == CNT_W'(WORDS - 1));
  // A beat is taken only when the bus is ours, memory is ready and no flush
  // is pending; a flush in the last-word cycle therefore loses the line.
  assign w_accept = (r_state == FILL) & ~w_dbusy & ~mem_iwait & ~iflush;

  assign w_fill_addr = {r_miss_tag, r_miss_idx, {(OFF_W+2){1'b0}}}
                     | {{(30-CNT_W){1'b0}}, r_cnt, 2'b00};

  // Next-state and output decode; refill address is only driven in FILL.
  always_comb begin
    w_state_nxt = r_state;
    ihit        = 1'b0;
    mem_iREN    = 1'b0;
    mem_iaddr   = '0;
    imemload    = r_data[w_idx][w_off];
    case (r_state)
      IDLE: begin
        ihit = w_hit;
        if (w_miss) w_state_nxt = FILL;
      end
      FILL: begin
        mem_iREN  = ~w_dbusy;
        mem_iaddr = w_fill_addr;
        if (iflush)                 w_state_nxt = IDLE;
        else if (w_accept & w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Valid bits: flush clears everything, a completed refill marks its set.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                  r_valid <= '0;
    else if (iflush)            r_valid <= '0;
    else if (w_accept & w_last) r_valid[r_miss_idx] <= 1'b1;
  end

  // Miss latch, refill counter, tag and data storage (not reset).
  always_ff @(posedge CLK) begin
    if (w_miss) begin
      r_miss_tag <= w_tag;
      r_miss_idx <= w_idx;
      r_cnt      <= '0;
    end
    if (w_accept) begin
      r_data[r_miss_idx][r_cnt] <= mem_iload;
      if (w_last) r_tag[r_miss_idx] <= r_miss_tag;
      else        r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_icache_param.sv
// Scenario bench for icache_param (SETS=16, WORDS=2): each fetch pushes the
// expected word to a scoreboard queue, which is popped when ihit appears.
module tb_icache_param;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        dREN = 1'b0, dWEN = 1'b0, iflush = 1'b0;
  logic        ihit, mem_iREN, mem_iwait = 1'b0;
  logic [31:0] imemload, mem_iaddr, mem_iload;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];
  logic [32:0] log_q [$];   // per-cycle {mem_iREN, mem_iaddr} before the hit

  icache_param #(.SETS(16), .WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .imemaddr(imemaddr),
    .dREN(dREN), .dWEN(dWEN), .iflush(iflush), .ihit(ihit),
    .imemload(imemload), .mem_iREN(mem_iREN), .mem_iaddr(mem_iaddr),
    .mem_iwait(mem_iwait), .mem_iload(mem_iload)
  );

  always #5 CLK = ~CLK;

  // Backing memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h100)      return 32'hAAAA0000;
    else if (w == 32'h104) return 32'hBBBB0001;
    else                   return {~w[15:0], w[15:0]};
  endfunction

  always_comb mem_iload = mem_word(mem_iaddr);

  // Issue one fetch and hold it until ihit. wm/dm give mem_iwait/dREN per
  // cycle (bit n = cycle n after the request). Returns cycles to hit and word.
  task automatic run_req(input logic [31:0] a, input logic [31:0] wm,
                         input logic [31:0] dm, output int cyc,
                         output logic [31:0] got);
    exp_q.push_back(mem_word(a));
    log_q.delete();
    got = 'x;
    @(posedge CLK); #1;
    iREN = 1'b1; imemaddr = a; cyc = 0;
    forever begin
      mem_iwait = (cyc < 32) ? wm[cyc] : 1'b0;
      dREN      = (cyc < 32) ? dm[cyc] : 1'b0;
      #1;
      if (ihit) begin
        got = imemload;
        break;
      end
      log_q.push_back({mem_iREN, mem_iaddr});
      if (cyc >= 60) begin
        total++; bad++;
        $display("FAIL timeout addr=%h no ihit after %0d cycles", a, cyc);
        break;
      end
      @(posedge CLK); #1;
      cyc++;
    end
    @(posedge CLK); #1;
    iREN = 1'b0; mem_iwait = 1'b0; dREN = 1'b0;
  endtask

  task automatic do_flush();
    @(posedge CLK); #1; iflush = 1'b1;
    @(posedge CLK); #1; iflush = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #3;
    total++; if (ihit !== 1'b0)      begin bad++; $display("FAIL rst_ihit got=%b exp=0", ihit); end
    total++; if (mem_iREN !== 1'b0)  begin bad++; $display("FAIL rst_mem_iREN got=%b exp=0", mem_iREN); end
    total++; if (mem_iaddr !== 32'h0) begin bad++; $display("FAIL rst_mem_iaddr got=%h exp=0", mem_iaddr); end
    @(posedge CLK); #1; nRST = 1'b1;
  endtask

  task automatic test_miss_fill();
    int cyc; logic [31:0] got, e;
    run_req(32'h104, 0, 0, cyc, got);
    e = exp_q.pop_front();
    total++; if (cyc !== 3) begin bad++; $display("FAIL miss_latency got=%0d exp=3", cyc); end
    total++; if (log_q[1] !== {1'b1, 32'h100}) begin bad++; $display("FAIL miss_word0_addr got=%h exp=1_00000100", log_q[1]); end
    total++; if (log_q[2] !== {1'b1, 32'h104}) begin bad++; $display("FAIL miss_word1_addr got=%h exp=1_00000104", log_q[2]); end
    total++; if (got !== e) begin bad++; $display("FAIL miss_data got=%h exp=%h", got, e); end
    run_req(32'h100, 0, 0, cyc, got);
    e = exp_q.pop_front();
    total++; if (cyc !== 0) begin bad++; $display("FAIL hit_latency got=%0d exp=0", cyc); end
    total++; if (got !== e) begin bad++; $display("FAIL hit_data got=%h exp=%h", got, e); end
  endtask

  task automatic test_conflict();
    int cyc; logic [31:0] got, e;
    run_req(32'h904, 0, 0, cyc, got);
    e = exp_q.pop_front();
    total++; if (cyc !== 3) begin bad++; $display("FAIL conflict_latency got=%0d exp=3", cyc); end
    total++; if (log_q[1] !== {1'b1, 32'h900}) begin bad++; $display("FAIL conflict_word0_addr got=%h exp=1_00000900", log_q[1]); end
    total++; if (log_q[2] !== {1'b1, 32'h904}) begin bad++; $display("FAIL conflict_word1_addr got=%h exp=1_00000904", log_q[2]); end
    total++; if (got !== e) begin bad++; $display("FAIL conflict_data got=%h exp=%h", got, e); end
    run_req(32'h100, 0, 0, cyc, got);
    e = exp_q.pop_front();
    total++; if (cyc !== 3) begin bad++; $display("FAIL replaced_latency got=%0d exp=3", cyc); end
    total++; if (got !== e) begin bad++; $display("FAIL replaced_data got=%h exp=%h", got, e); end
  endtask

  task automatic test_wait();
    int cyc, held; logic [31:0] got, e;
    do_flush();
    // iwait high in cycles 1-3 and 5-7: three wait cycles before each word.
    run_req(32'h100, 32'h0000_00EE, 0, cyc, got);
    e = exp_q.pop_front();
    held = 0;
    foreach (log_q[i]) if (log_q[i] === {1'b1, 32'h100}) held++;
    total++; if (cyc !== 9) begin bad++; $display("FAIL wait_latency got=%0d exp=9", cyc); end
    total++; if (held !== 4) begin bad++; $display("FAIL wait_addr_hold got=%0d exp=4", held); end
    total++; if (log_q[5] !== {1'b1, 32'h104}) begin bad++; $display("FAIL wait_word1_addr got=%h exp=1_00000104", log_q[5]); end
    total++; if (got !== e) begin bad++; $display("FAIL wait_data got=%h exp=%h", got, e); end
  endtask

  task automatic test_data_prio();
    int cyc; logic [31:0] got, e;
    do_flush();
    // dREN in cycles 2-3, right after word 0 is accepted in cycle 1.
    run_req(32'h104, 0, 32'h0000_000C, cyc, got);
    e = exp_q.pop_front();
    total++; if (cyc !== 5) begin bad++; $display("FAIL prio_latency got=%0d exp=5", cyc); end
    total++; if (log_q[2] !== {1'b0, 32'h104}) begin bad++; $display("FAIL prio_stall0 got=%h exp=0_00000104", log_q[2]); end
    total++; if (log_q[3] !== {1'b0, 32'h104}) begin bad++; $display("FAIL prio_stall1 got=%h exp=0_00000104", log_q[3]); end
    total++; if (log_q[4] !== {1'b1, 32'h104}) begin bad++; $display("FAIL prio_resume got=%h exp=1_00000104", log_q[4]); end
    total++; if (got !== e) begin bad++; $display("FAIL prio_data got=%h exp=%h", got, e); end
  endtask

  task automatic test_flush();
    int cyc; logic [31:0] got, e;
    run_req(32'h904, 0, 0, cyc, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL flush_setup_data got=%h exp=%h", got, e); end
    // Start a fill of 0x104 and flush while its last word is on the bus.
    @(posedge CLK); #1; iREN = 1'b1; imemaddr = 32'h104;
    @(posedge CLK); #1;
    @(posedge CLK); #1; iflush = 1'b1; #1;
    total++; if (ihit !== 1'b0) begin bad++; $display("FAIL flush_ihit got=%b exp=0", ihit); end
    @(posedge CLK); #1; iflush = 1'b0; iREN = 1'b0; #1;
    total++; if (mem_iREN !== 1'b0) begin bad++; $display("FAIL flush_idle_mem_iREN got=%b exp=0", mem_iREN); end
    run_req(32'h104, 0, 0, cyc, got);
    e = exp_q.pop_front();
    total++; if (cyc !== 3) begin bad++; $display("FAIL flush_refetch_latency got=%0d exp=3", cyc); end
    total++; if (got !== e) begin bad++; $display("FAIL flush_refetch_data got=%h exp=%h", got, e); end
    run_req(32'h900, 0, 0, cyc, got);
    e = exp_q.pop_front();
    total++; if (cyc !== 3) begin bad++; $display("FAIL flush_old_line_latency got=%0d exp=3", cyc); end
    total++; if (got !== e) begin bad++; $display("FAIL flush_old_line_data got=%h exp=%h", got, e); end
  endtask

  task automatic test_reset_midfill();
    int cyc; logic [31:0] got, e;
    run_req(32'h100, 0, 0, cyc, got);
    void'(exp_q.pop_front());
    // 0x100 is now resident; begin a conflicting fill and reset inside it.
    @(posedge CLK); #1; iREN = 1'b1; imemaddr = 32'h904;
    @(posedge CLK); #1;
    total++; if (mem_iREN !== 1'b1) begin bad++; $display("FAIL midfill_active got=%b exp=1", mem_iREN); end
    #2; nRST = 1'b0; #1;
    total++; if (ihit !== 1'b0)      begin bad++; $display("FAIL midfill_rst_ihit got=%b exp=0", ihit); end
    total++; if (mem_iREN !== 1'b0)  begin bad++; $display("FAIL midfill_rst_mem_iREN got=%b exp=0", mem_iREN); end
    total++; if (mem_iaddr !== 32'h0) begin bad++; $display("FAIL midfill_rst_mem_iaddr got=%h exp=0", mem_iaddr); end
    iREN = 1'b0;
    @(posedge CLK); #1; nRST = 1'b1;
    run_req(32'h100, 0, 0, cyc, got);
    e = exp_q.pop_front();
    total++; if (cyc !== 3) begin bad++; $display("FAIL post_rst_latency got=%0d exp=3", cyc); end
    total++; if (got !== e) begin bad++; $display("FAIL post_rst_data got=%h exp=%h", got, e); end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_conflict();
    test_wait();
    test_data_prio();
    test_flush();
    test_reset_midfill();
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
